// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between two bus masters, the arbiter and a synchronous memory.
// The arbiter uses the slave modport; the environment driving masters and memory uses master.
interface mem_bus_arbiter_if;
  logic        m0_req;
  logic        m1_req;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic [3:0]  m0_byte_en;
  logic [3:0]  m1_byte_en;
  logic        m0_we;
  logic        m1_we;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_rvalid;
  logic        m1_rvalid;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_data_i;
  logic [3:0]  bus_data_en;
  logic        bus_write_en;
  logic [31:0] bus_data_o;

  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_byte_en, m1_byte_en, m0_we, m1_we, bus_data_o,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output bus_addr, bus_data_i, bus_data_en, bus_write_en
  );

  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_byte_en, m1_byte_en, m0_we, m1_we, bus_data_o,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  bus_addr, bus_data_i, bus_data_en, bus_write_en
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter onto a synchronous memory bus with tagged read-return routing.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module mem_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave mif
);

  // Only latencies of 1 and 2 are meaningful; anything else behaves as 1.
  localparam int DEPTH = (READ_LATENCY == 2) ? 2 : 1;

  logic       gnt_valid_s;
  logic       gnt_port_s;
  logic       contend_port_s;
  logic       read_s;
  logic [1:0] tag_push_s;
  // Tags are kept one-hot {m1, m0} so the last stage drives rvalid straight from flops.
  logic [1:0] tag_r [DEPTH];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_r;

  // Priority pointer hands contention to the port that did not win last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (gnt_valid_s) begin
      ptr_r <= ~gnt_port_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign contend_port_s = ptr_r;
`else
  assign contend_port_s = 1'b0;
`endif

  // Arbitration: pick the winning port, nothing while reset is held
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_port_s  = 1'b0;
    if (!rst_n) begin
      gnt_valid_s = 1'b0;
      gnt_port_s  = 1'b0;
    end else begin
      case ({mif.m1_req, mif.m0_req})
        2'b01: begin
          gnt_valid_s = 1'b1;
          gnt_port_s  = 1'b0;
        end
        2'b10: begin
          gnt_valid_s = 1'b1;
          gnt_port_s  = 1'b1;
        end
        2'b11: begin
          gnt_valid_s = 1'b1;
          gnt_port_s  = contend_port_s;
        end
        default: begin
          gnt_valid_s = 1'b0;
          gnt_port_s  = 1'b0;
        end
      endcase
    end
  end

  // Grant decode, bus mux and read-tag generation
  always_comb begin
    mif.m0_gnt       = gnt_valid_s & ~gnt_port_s;
    mif.m1_gnt       = gnt_valid_s & gnt_port_s;
    mif.bus_addr     = 32'h0000_0000;
    mif.bus_data_i   = 32'h0000_0000;
    mif.bus_data_en  = 4'h0;
    mif.bus_write_en = 1'b0;
    read_s           = 1'b0;
    if (gnt_valid_s && gnt_port_s) begin
      mif.bus_addr     = mif.m1_addr;
      mif.bus_data_i   = mif.m1_wdata;
      mif.bus_data_en  = mif.m1_byte_en;
      mif.bus_write_en = mif.m1_we;
      read_s           = ~mif.m1_we;
    end else if (gnt_valid_s) begin
      mif.bus_addr     = mif.m0_addr;
      mif.bus_data_i   = mif.m0_wdata;
      mif.bus_data_en  = mif.m0_byte_en;
      mif.bus_write_en = mif.m0_we;
      read_s           = ~mif.m0_we;
    end else begin
      read_s           = 1'b0;
    end
    tag_push_s = {read_s & gnt_port_s, read_s & ~gnt_port_s};
  end

  // Read-tag shift pipeline; reset drops every read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i] <= 2'b00;
      end
    end else begin
      tag_r[0] <= tag_push_s;
      for (int i = 1; i < DEPTH; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign mif.m0_rvalid = tag_r[DEPTH-1][0];
  assign mif.m1_rvalid = tag_r[DEPTH-1][1];
  assign mif.m0_rdata  = mif.bus_data_o;
  assign mif.m1_rdata  = mif.bus_data_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: latency-1 instance driven from a vector table,
// latency-2 instance driven by hand-written return-order and reset sequences.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if ifa ();
  mem_bus_arbiter_if ifb ();

  mem_bus_arbiter #(.READ_LATENCY(1)) dut_a (.clk(clk), .rst_n(rst_n), .mif(ifa.slave));
  mem_bus_arbiter #(.READ_LATENCY(2)) dut_b (.clk(clk), .rst_n(rst_n), .mif(ifb.slave));

  function automatic logic [31:0] init_word(input int idx);
    logic [7:0] lo;
    lo = idx[7:0];
    if (idx == 32'h40)      return 32'hDEAD_BEEF;
    else if (idx == 32'h10) return 32'hAAAA_AAAA;
    else                    return {24'hC0DE00, lo};
  endfunction

  // Memory models: byte-enabled writes, READ_LATENCY-deep read registers
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] rd_a;
  logic [31:0] rd_b1;
  logic [31:0] rd_b2;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    end else if (ifa.bus_write_en) begin
      for (int b = 0; b < 4; b++)
        if (ifa.bus_data_en[b]) mem_a[ifa.bus_addr[9:2]][b*8 +: 8] <= ifa.bus_data_i[b*8 +: 8];
    end
    rd_a <= mem_a[ifa.bus_addr[9:2]];
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < 256; j++) mem_b[j] <= init_word(j);
    end else if (ifb.bus_write_en) begin
      for (int c = 0; c < 4; c++)
        if (ifb.bus_data_en[c]) mem_b[ifb.bus_addr[9:2]][c*8 +: 8] <= ifb.bus_data_i[c*8 +: 8];
    end
    rd_b1 <= mem_b[ifb.bus_addr[9:2]];
    rd_b2 <= rd_b1;
  end

  assign ifa.bus_data_o = rd_a;
  assign ifb.bus_data_o = rd_b2;

  typedef struct {
    logic        r0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  b1;
    logic [1:0]  g;
    logic [1:0]  rv;
    logic [31:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic w0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic [3:0] b0,
                              input logic r1, input logic w1, input logic [31:0] a1,
                              input logic [31:0] d1, input logic [3:0] b1,
                              input logic [1:0] g, input logic [1:0] rv, input logic [31:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
    v.g = g; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  vec_t vecs [12];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input vec_t v);
    ifa.m0_req = v.r0; ifa.m0_we = v.w0; ifa.m0_addr = v.a0; ifa.m0_wdata = v.d0; ifa.m0_byte_en = v.b0;
    ifa.m1_req = v.r1; ifa.m1_we = v.w1; ifa.m1_addr = v.a1; ifa.m1_wdata = v.d1; ifa.m1_byte_en = v.b1;
  endtask

  task automatic set_b(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1);
    ifb.m0_req = r0; ifb.m0_we = 1'b0; ifb.m0_addr = a0; ifb.m0_wdata = 32'h0; ifb.m0_byte_en = 4'hF;
    ifb.m1_req = r1; ifb.m1_we = 1'b0; ifb.m1_addr = a1; ifb.m1_wdata = 32'h0; ifb.m1_byte_en = 4'hF;
  endtask

  task automatic check_b(input string name, input logic [1:0] g, input logic [1:0] rv, input logic [31:0] rd);
    check({name, "_gnt"}, {70'h0, ifb.m1_gnt, ifb.m0_gnt}, {70'h0, g});
    check({name, "_rvalid"}, {70'h0, ifb.m1_rvalid, ifb.m0_rvalid}, {70'h0, rv});
    if (rv != 2'b00)
      check({name, "_rdata"}, {8'h0, ifb.m1_rdata, ifb.m0_rdata}, {8'h0, rd, rd});
  endtask

  initial begin
    logic [68:0] exp_bus;
    vecs[0]  = mk(1, 0, 32'h100, 0, 4'hF,  0, 0, 0, 0, 0,  2'b01, 2'b00, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2'b00, 2'b01, 32'hDEAD_BEEF);
    vecs[2]  = mk(0, 0, 0, 0, 0,  1, 1, 32'h40, 32'h1234_5678, 4'b0011,  2'b10, 2'b00, 32'h0);
    vecs[3]  = mk(1, 0, 32'h40, 0, 4'hF,  0, 0, 0, 0, 0,  2'b01, 2'b00, 32'h0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2'b00, 2'b01, 32'hAAAA_5678);
    vecs[5]  = mk(0, 0, 0, 0, 0,  1, 0, 32'h0, 0, 4'hF,  2'b10, 2'b00, 32'h0);
    vecs[6]  = mk(1, 0, 32'h4, 0, 4'hF,  1, 0, 32'h8, 0, 4'hF,  2'b01, 2'b10, 32'hC0DE_0000);
    vecs[7]  = mk(1, 0, 32'h4, 0, 4'hF,  1, 0, 32'h8, 0, 4'hF,  RR ? 2'b10 : 2'b01, 2'b01, 32'hC0DE_0001);
    vecs[8]  = mk(1, 0, 32'h4, 0, 4'hF,  1, 0, 32'h8, 0, 4'hF,  2'b01,
                  RR ? 2'b10 : 2'b01, RR ? 32'hC0DE_0002 : 32'hC0DE_0001);
    vecs[9]  = mk(1, 0, 32'h4, 0, 4'hF,  1, 0, 32'h8, 0, 4'hF,  RR ? 2'b10 : 2'b01, 2'b01, 32'hC0DE_0001);
    vecs[10] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2'b00,
                  RR ? 2'b10 : 2'b01, RR ? 32'hC0DE_0002 : 32'hC0DE_0001);
    vecs[11] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2'b00, 2'b00, 32'h0);

    // Reset held with requests pending: everything must stay idle
    rst_n = 1'b0;
    set_a(mk(1, 1, 32'h44, 32'h5555_5555, 4'hF,  1, 0, 32'h48, 0, 4'hF,  2'b00, 2'b00, 32'h0));
    set_b(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step();
    check("rst_gnt", {70'h0, ifa.m1_gnt, ifa.m0_gnt}, 72'h0);
    check("rst_bus", {3'h0, ifa.bus_addr, ifa.bus_data_i, ifa.bus_data_en, ifa.bus_write_en}, 72'h0);
    check("rst_rvalid", {70'h0, ifa.m1_rvalid, ifa.m0_rvalid}, 72'h0);

    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_a(vecs[i]);
      #1;
      check($sformatf("row%0d_gnt", i), {70'h0, ifa.m1_gnt, ifa.m0_gnt}, {70'h0, vecs[i].g});
      if (vecs[i].g == 2'b01)
        exp_bus = {vecs[i].a0, vecs[i].d0, vecs[i].b0, vecs[i].w0};
      else if (vecs[i].g == 2'b10)
        exp_bus = {vecs[i].a1, vecs[i].d1, vecs[i].b1, vecs[i].w1};
      else
        exp_bus = 69'h0;
      check($sformatf("row%0d_bus", i),
            {3'h0, ifa.bus_addr, ifa.bus_data_i, ifa.bus_data_en, ifa.bus_write_en}, {3'h0, exp_bus});
      check($sformatf("row%0d_rvalid", i), {70'h0, ifa.m1_rvalid, ifa.m0_rvalid}, {70'h0, vecs[i].rv});
      if (vecs[i].rv != 2'b00)
        check($sformatf("row%0d_rdata", i), {8'h0, ifa.m1_rdata, ifa.m0_rdata},
              {8'h0, vecs[i].rd, vecs[i].rd});
      step();
    end

    // Latency 2, alternating masters: returns two cycles after each grant, in order
    set_b(1'b1, 32'h0, 1'b0, 32'h0);  #1; check_b("l2_c0", 2'b01, 2'b00, 32'h0); step();
    set_b(1'b0, 32'h0, 1'b1, 32'h4);  #1; check_b("l2_c1", 2'b10, 2'b00, 32'h0); step();
    set_b(1'b1, 32'h8, 1'b0, 32'h0);  #1; check_b("l2_c2", 2'b01, 2'b01, 32'hC0DE_0000); step();
    set_b(1'b0, 32'h0, 1'b0, 32'h0);  #1; check_b("l2_c3", 2'b00, 2'b10, 32'hC0DE_0001); step();
    #1; check_b("l2_c4", 2'b00, 2'b01, 32'hC0DE_0002); step();
    #1; check_b("l2_c5", 2'b00, 2'b00, 32'h0); step();

    // Read granted, then reset next cycle: it must never return
    set_b(1'b1, 32'h8, 1'b0, 32'h0);  #1; check_b("rs_gnt", 2'b01, 2'b00, 32'h0); step();
    rst_n = 1'b0;
    set_b(1'b1, 32'h10, 1'b1, 32'h14);
    #1;
    check_b("rs_hold0", 2'b00, 2'b00, 32'h0);
    check("rs_bus", {3'h0, ifb.bus_addr, ifb.bus_data_i, ifb.bus_data_en, ifb.bus_write_en}, 72'h0);
    step(); #1; check_b("rs_hold1", 2'b00, 2'b00, 32'h0);
    step();
    rst_n = 1'b1;
    set_b(1'b1, 32'h4, 1'b1, 32'h0);  #1; check_b("rs_ptr", 2'b01, 2'b00, 32'h0); step();
    set_b(1'b0, 32'h0, 1'b0, 32'h0);  #1; check_b("rs_post0", 2'b00, 2'b00, 32'h0); step();
    #1; check_b("rs_post1", 2'b00, 2'b01, 32'hC0DE_0001); step();
    #1; check_b("rs_post2", 2'b00, 2'b00, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
